// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX boundary: instruction field positions, ALUOp codes and the control bundle.
package id_ex_stage_pkg;

  localparam int CTRL_W = 8;

  localparam int IR_RD_LO      = 7;
  localparam int IR_RD_HI      = 11;
  localparam int IR_FUNCT3_LO  = 12;
  localparam int IR_FUNCT3_HI  = 14;
  localparam int IR_RS1_LO     = 15;
  localparam int IR_RS1_HI     = 19;
  localparam int IR_RS2_LO     = 20;
  localparam int IR_RS2_HI     = 24;
  localparam int IR_FUNCT7B5   = 30;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10
  } aluop_e;

  // Bit order matches the control-unit port order, MSB first.
  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t gate_ctrl(input logic valid, input ctrl_t ctrl);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard check between the load sitting in EX and the instruction in decode.
// Zero latency; no state, no backpressure of its own.
module load_use_detect
  import id_ex_stage_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_alusrc,
  input  logic       id_memwrite,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       luh
);

  logic uses_rs2;
  logic rs1_match;
  logic rs2_match;
  logic ex_is_load;

  // Stores read rs2 even though alusrc selects the immediate.
  assign uses_rs2   = ~id_alusrc | id_memwrite;
  assign rs1_match  = (ex_rd == id_rs1);
  assign rs2_match  = uses_rs2 & (ex_rd == id_rs2);
  assign ex_is_load = ex_valid & ex_memread & (ex_rd != 5'd0);

  assign luh = id_valid & ex_is_load & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a bubble counter.
// Latency 1 cycle; hold freezes the stage, stall_if_id holds upstream on load-use or hold.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [N-1:0]     id_instr,
  input  logic             id_branch,
  input  logic             id_memread,
  input  logic             id_memtoreg,
  input  logic             id_memwrite,
  input  logic             id_alusrc,
  input  logic             id_regwrite,
  input  logic [1:0]       id_aluop,
  input  logic [N-1:0]     id_rs1_data,
  input  logic [N-1:0]     id_rs2_data,
  input  logic [N-1:0]     id_imm,
  input  logic [N-1:0]     id_pc,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_memread,
  output logic             ex_memtoreg,
  output logic             ex_memwrite,
  output logic             ex_alusrc,
  output logic             ex_regwrite,
  output logic [1:0]       ex_aluop,
  output logic [N-1:0]     ex_rs1_data,
  output logic [N-1:0]     ex_rs2_data,
  output logic [N-1:0]     ex_imm,
  output logic [N-1:0]     ex_pc,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             stall_if_id,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [CTRL_W-1:0] id_ctrl_bits;
  ctrl_t             id_ctrl;
  ctrl_t             ex_ctrl;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic [2:0]        id_funct3;
  logic              id_funct7b5;
  logic              luh;
  logic              bubble;
  logic              unused_instr;

  assign id_ctrl_bits = {id_branch, id_memread, id_memtoreg, id_memwrite,
                         id_alusrc, id_regwrite, id_aluop};
  assign id_ctrl      = ctrl_t'(id_ctrl_bits);

  assign id_rs1      = id_instr[IR_RS1_HI:IR_RS1_LO];
  assign id_rs2      = id_instr[IR_RS2_HI:IR_RS2_LO];
  assign id_rd       = id_instr[IR_RD_HI:IR_RD_LO];
  assign id_funct3   = id_instr[IR_FUNCT3_HI:IR_FUNCT3_LO];
  assign id_funct7b5 = id_instr[IR_FUNCT7B5];

  // Opcode and the rest of funct7 are consumed by the control unit, not here.
  assign unused_instr = ^{id_instr[N-1:31], id_instr[29:25], id_instr[6:0]};

  load_use_detect u_load_use_detect (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_alusrc   (id_alusrc),
    .id_memwrite (id_memwrite),
    .ex_valid    (ex_valid),
    .ex_memread  (ex_ctrl.memread),
    .ex_rd       (ex_rd),
    .luh         (luh)
  );

  // A flush already kills the dependent instruction, so it must not also stall it.
  assign stall_if_id = (luh & ~flush) | hold;
  assign bubble      = flush | (~hold & luh);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      bubble_cnt  <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      bubble_cnt  <= bubble_cnt + CNT_W'(1);
    end else if (!hold) begin
      ex_valid    <= id_valid;
      ex_ctrl     <= gate_ctrl(id_valid, id_ctrl);
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
    end
  end

  assign ex_branch   = ex_ctrl.branch;
  assign ex_memread  = ex_ctrl.memread;
  assign ex_memtoreg = ex_ctrl.memtoreg;
  assign ex_memwrite = ex_ctrl.memwrite;
  assign ex_alusrc   = ex_ctrl.alusrc;
  assign ex_regwrite = ex_ctrl.regwrite;
  assign ex_aluop    = ex_ctrl.aluop;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized run against a behavioural model.
module tb_id_ex_stage;

  localparam int N  = 32;
  localparam int CW = 4;

  // control vector order: branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop[1:0]
  localparam logic [7:0] C_R    = 8'b0000_0110;
  localparam logic [7:0] C_LW   = 8'b0110_1100;
  localparam logic [7:0] C_ADDI = 8'b0000_1110;
  localparam logic [7:0] C_SW   = 8'b0001_1000;
  localparam logic [7:0] C_BEQ  = 8'b1000_0001;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [N-1:0] id_instr;
  logic id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite;
  logic [1:0] id_aluop;
  logic [N-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic flush, hold;
  logic ex_valid;
  logic ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite;
  logic [1:0] ex_aluop;
  logic [N-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic ex_funct7b5;
  logic stall_if_id;
  logic [CW-1:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          valid;
    logic [7:0]    ctrl;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [N-1:0]  imm;
    logic [N-1:0]  pc;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [2:0]    f3;
    logic          f7;
    logic [CW-1:0] cnt;
  } ex_view_t;

  ex_view_t m;

  id_ex_stage #(.N(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
    .id_memwrite(id_memwrite), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
    .id_aluop(id_aluop), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
    .ex_regwrite(ex_regwrite), .ex_aluop(ex_aluop), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .stall_if_id(stall_if_id), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic ex_view_t dut_view();
    ex_view_t v;
    v.valid = ex_valid;
    v.ctrl  = {ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc, ex_regwrite, ex_aluop};
    v.a     = ex_rs1_data;
    v.b     = ex_rs2_data;
    v.imm   = ex_imm;
    v.pc    = ex_pc;
    v.rs1   = ex_rs1;
    v.rs2   = ex_rs2;
    v.rd    = ex_rd;
    v.f3    = ex_funct3;
    v.f7    = ex_funct7b5;
    v.cnt   = bubble_cnt;
    return v;
  endfunction

  function automatic logic [N-1:0] mk(input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic f7b5);
    return {1'b0, f7b5, 5'b0, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // Hazard as stated by the pipeline rules: a load in EX writing a register decode reads.
  function automatic bit model_luh();
    bit ex_loads, reads_rs2;
    logic [4:0] r1, r2;
    r1        = id_instr[19:15];
    r2        = id_instr[24:20];
    ex_loads  = m.valid && m.ctrl[6] && (m.rd != 5'd0);
    reads_rs2 = !id_alusrc || id_memwrite;
    return id_valid && ex_loads && (m.rd == r1 || (reads_rs2 && m.rd == r2));
  endfunction

  function automatic bit model_stall();
    return (model_luh() && !flush) || hold;
  endfunction

  task automatic drive(input logic v, input logic [N-1:0] instr, input logic [7:0] c,
                       input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] imm,
                       input logic [N-1:0] pc, input logic fl, input logic hd);
    id_valid = v;
    id_instr = instr;
    {id_branch, id_memread, id_memtoreg, id_memwrite, id_alusrc, id_regwrite, id_aluop} = c;
    id_rs1_data = a;
    id_rs2_data = b;
    id_imm = imm;
    id_pc = pc;
    flush = fl;
    hold = hd;
  endtask

  // One clock: predict the EX contents from the current inputs, then let the edge happen.
  task automatic step();
    ex_view_t nx;
    nx = m;
    if (flush || (!hold && model_luh())) begin
      nx = '0;
      nx.cnt = m.cnt + 1'b1;
    end else if (!hold) begin
      nx.valid = id_valid;
      nx.ctrl  = id_valid ? {id_branch, id_memread, id_memtoreg, id_memwrite,
                             id_alusrc, id_regwrite, id_aluop} : 8'h00;
      nx.a     = id_rs1_data;
      nx.b     = id_rs2_data;
      nx.imm   = id_imm;
      nx.pc    = id_pc;
      nx.rs1   = id_instr[19:15];
      nx.rs2   = id_instr[24:20];
      nx.rd    = id_instr[11:7];
      nx.f3    = id_instr[14:12];
      nx.f7    = id_instr[30];
    end
    @(posedge clk);
    m = nx;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 8'h00, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    drive(1'b1, '1, 8'hff, '1, '1, '1, '1, 1'b1, 1'b1);
    rst = 1'b1;
    #3;
    n_cmp++;
    if ({ex_valid, bubble_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_async got valid=%b cnt=%0d want 0/0", ex_valid, bubble_cnt);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (dut_view() !== '0) begin
      n_bad++;
      $display("FAIL reset_held got %h want all zero", dut_view());
    end
    idle();
    m = '0;
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (dut_view() !== '0 || stall_if_id !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release got view=%h stall=%b want zero/0", dut_view(), stall_if_id);
    end
  endtask

  task automatic test_rtype();
    drive(1'b1, mk(5'd3, 5'd1, 5'd2, 3'd0, 1'b0), C_R, 32'h11, 32'h22, 32'h0, 32'h100, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({ex_valid, ex_regwrite, ex_aluop, ex_rd, ex_memread} !== {1'b1, 1'b1, 2'b10, 5'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL rtype got v=%b rw=%b op=%b rd=%0d mr=%b want 1/1/10/3/0",
               ex_valid, ex_regwrite, ex_aluop, ex_rd, ex_memread);
    end
    n_cmp++;
    if ({ex_rs1_data, ex_rs2_data, ex_pc} !== {32'h11, 32'h22, 32'h100}) begin
      n_bad++;
      $display("FAIL rtype_data got %h %h %h want 11 22 100", ex_rs1_data, ex_rs2_data, ex_pc);
    end
  endtask

  task automatic test_load_use();
    logic [CW-1:0] c0;
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, 32'h40, 32'h0, 32'h0, 32'h104, 1'b0, 1'b0);
    step();
    c0 = m.cnt;
    drive(1'b1, mk(5'd6, 5'd5, 5'd2, 3'd0, 1'b0), C_R, 32'h1, 32'h2, 32'h0, 32'h108, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b1) begin
      n_bad++;
      $display("FAIL luh_stall got %b want 1", stall_if_id);
    end
    step();
    n_cmp++;
    if ({ex_valid, ex_regwrite, ex_memwrite, stall_if_id} !== 4'b0000 || bubble_cnt !== c0 + 1'b1) begin
      n_bad++;
      $display("FAIL luh_bubble got v=%b rw=%b mw=%b stall=%b cnt=%0d want 0/0/0/0 cnt=%0d",
               ex_valid, ex_regwrite, ex_memwrite, stall_if_id, bubble_cnt, c0 + 1'b1);
    end
    step();
    n_cmp++;
    if ({ex_valid, ex_rd, ex_rs1} !== {1'b1, 5'd6, 5'd5} || bubble_cnt !== c0 + 1'b1) begin
      n_bad++;
      $display("FAIL luh_resume got v=%b rd=%0d rs1=%0d cnt=%0d want 1/6/5 cnt=%0d",
               ex_valid, ex_rd, ex_rs1, bubble_cnt, c0 + 1'b1);
    end
  endtask

  task automatic test_no_hazard();
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd6, 5'd7, 5'd5, 3'd0, 1'b0), C_ADDI, '0, '0, 32'd4, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_bad++;
      $display("FAIL addi_rs2_field got stall=%b want 0", stall_if_id);
    end
    step();
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd0, 5'd2, 5'd5, 3'd2, 1'b0), C_SW, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b1) begin
      n_bad++;
      $display("FAIL store_rs2_use got stall=%b want 1", stall_if_id);
    end
    step();
    step();
    drive(1'b1, mk(5'd0, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd6, 5'd0, 5'd0, 3'd0, 1'b0), C_R, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_load got stall=%b want 0", stall_if_id);
    end
    step();
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b0, mk(5'd6, 5'd5, 5'd2, 3'd0, 1'b0), C_R, '0, '0, '0, '0, 1'b0, 1'b0);
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_decode_stall got %b want 0", stall_if_id);
    end
    step();
    n_cmp++;
    if ({ex_valid, ex_regwrite, ex_aluop, ex_rd} !== {1'b0, 1'b0, 2'b00, 5'd6}) begin
      n_bad++;
      $display("FAIL invalid_ctrl_gate got v=%b rw=%b op=%b rd=%0d want 0/0/00/6",
               ex_valid, ex_regwrite, ex_aluop, ex_rd);
    end
  endtask

  task automatic test_flush_hold();
    logic [CW-1:0] c0;
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd6, 5'd5, 5'd2, 3'd0, 1'b0), C_R, 32'h9, 32'h9, '0, 32'h200, 1'b1, 1'b1);
    c0 = m.cnt;
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_hold_stall got %b want 1", stall_if_id);
    end
    step();
    n_cmp++;
    if ({ex_valid, ex_rd, ex_pc} !== '0 || bubble_cnt !== c0 + 1'b1) begin
      n_bad++;
      $display("FAIL flush_over_hold got v=%b rd=%0d pc=%h cnt=%0d want 0/0/0 cnt=%0d",
               ex_valid, ex_rd, ex_pc, bubble_cnt, c0 + 1'b1);
    end
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd6, 5'd5, 5'd2, 3'd0, 1'b0), C_R, '0, '0, '0, '0, 1'b1, 1'b0);
    c0 = m.cnt;
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_masks_luh got stall=%b want 0", stall_if_id);
    end
    step();
    n_cmp++;
    if (ex_valid !== 1'b0 || bubble_cnt !== c0 + 1'b1) begin
      n_bad++;
      $display("FAIL flush_luh_once got v=%b cnt=%0d want 0 cnt=%0d", ex_valid, bubble_cnt, c0 + 1'b1);
    end
    drive(1'b1, mk(5'd3, 5'd1, 5'd2, 3'd0, 1'b0), C_R, 32'h33, 32'h44, '0, 32'h300, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 8'($urandom), $urandom, $urandom, $urandom, $urandom, 1'b0, 1'b1);
      #1;
      n_cmp++;
      if (stall_if_id !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_stall[%0d] got %b want 1", i, stall_if_id);
      end
      step();
      n_cmp++;
      if ({ex_valid, ex_rd, ex_rs1_data, ex_pc} !== {1'b1, 5'd3, 32'h33, 32'h300} || dut_view() !== m) begin
        n_bad++;
        $display("FAIL hold_frozen[%0d] got %h want %h", i, dut_view(), m);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, mk(5'd5, 5'd1, 5'd0, 3'd2, 1'b0), C_LW, '0, '0, '0, '0, 1'b0, 1'b0);
    step();
    drive(1'b1, mk(5'd6, 5'd5, 5'd2, 3'd0, 1'b0), C_R, '0, '0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    m = '0;
    #1;
    n_cmp++;
    if ({stall_if_id, ex_valid, ex_memread} !== 3'b000 || bubble_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_stall got stall=%b v=%b mr=%b cnt=%0d want 0/0/0/0",
               stall_if_id, ex_valid, ex_memread, bubble_cnt);
    end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < (1 << CW) && m.cnt != {CW{1'b1}}; i++) begin
      drive(1'b1, mk(5'd1, 5'd2, 5'd3, 3'd0, 1'b0), C_R, '0, '0, '0, '0, 1'b1, 1'b0);
      step();
    end
    n_cmp++;
    if (bubble_cnt !== {CW{1'b1}}) begin
      n_bad++;
      $display("FAIL cnt_max got %0d want %0d", bubble_cnt, (1 << CW) - 1);
    end
    step();
    n_cmp++;
    if (bubble_cnt !== '0) begin
      n_bad++;
      $display("FAIL cnt_wrap got %0d want 0", bubble_cnt);
    end
    idle();
    step();
  endtask

  task automatic test_random();
    logic [7:0] kinds [5];
    kinds = '{C_R, C_LW, C_ADDI, C_SW, C_BEQ};
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      logic [N-1:0] instr;
      c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : kinds[$urandom_range(0, 4)];
      instr = $urandom;
      instr[11:7]  = 5'($urandom_range(0, 7));
      instr[19:15] = 5'($urandom_range(0, 7));
      instr[24:20] = 5'($urandom_range(0, 7));
      drive(($urandom_range(0, 9) != 0), instr, c, $urandom, $urandom, $urandom, $urandom,
            ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) == 0));
      #1;
      n_cmp++;
      if (stall_if_id !== model_stall()) begin
        n_bad++;
        $display("FAIL rand_stall[%0d] got %b want %b", i, stall_if_id, model_stall());
      end
      step();
      n_cmp++;
      if (dut_view() !== m) begin
        n_bad++;
        $display("FAIL rand_ex[%0d] got %h want %h", i, dut_view(), m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_no_hazard();
    test_flush_hold();
    test_reset_mid_stall();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
